// File: rtl/argo_chan_wr_arb_if.sv
// ============================================================================
// Module   : argo_chan_wr_arb_if
// Brief    : Writer-side and FIFO-side bundle for the channel write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface argo_chan_wr_arb_if #(
  parameter int NUM_WR     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
);
  logic [NUM_WR-1:0]            wr_req;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic [NUM_WR-1:0]            wr_ack;
  logic                         fifo_full;
  logic                         fifo_wr_en;
  logic [DATA_WIDTH-1:0]        fifo_wr_data;
  logic [IDX_WIDTH-1:0]         grant_idx;
  logic                         busy;
  logic [31:0]                  write_count;

  modport master (
    input  wr_req, wr_data, fifo_full,
    output wr_ack, fifo_wr_en, fifo_wr_data, grant_idx, busy, write_count
  );

  modport slave (
    output wr_req, wr_data, fifo_full,
    input  wr_ack, fifo_wr_en, fifo_wr_data, grant_idx, busy, write_count
  );
endinterface

`default_nettype wire

// File: rtl/argo_chan_wr_arb.sv
// ============================================================================
// Module   : argo_chan_wr_arb
// Brief    : Round-robin arbiter granting one writer per two cycles into a
//            shared channel FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module argo_chan_wr_arb #(
  parameter int NUM_WR     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2,
  parameter int ARB_ID     = 7
) (
  input  logic                clk,
  input  logic                rst,
  argo_chan_wr_arb_if.master  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Empty for every legal parameter set; exists only to pin the legal ranges.
  if (NUM_WR < 2 || NUM_WR > 16 || (1 << IDX_WIDTH) < NUM_WR ||
      ARB_ID < 0 || ARB_ID > 65535) begin : g_param_illegal
  end

  state_t                state_q, state_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [NUM_WR-1:0]     wr_ack_q, wr_ack_d;
  logic [DATA_WIDTH-1:0] fifo_wr_data_q, fifo_wr_data_d;
  logic [IDX_WIDTH-1:0]  grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0]  last_idx_q, last_idx_d;
  logic [31:0]           write_count_q, write_count_d;

  logic [NUM_WR-1:0]                 req_hi;
  logic [NUM_WR-1:0]                 req_sel;
  logic [NUM_WR-1:0]                 win_oh;
  logic [IDX_WIDTH-1:0]              win_idx;
  logic [DATA_WIDTH-1:0]             win_data;
  logic [IDX_WIDTH-1:0][NUM_WR-1:0]  idx_col;
  logic [DATA_WIDTH-1:0][NUM_WR-1:0] data_col;

  // Requests strictly above the last winner take precedence; otherwise wrap to 0.
  for (genvar g = 0; g < NUM_WR; g++) begin : g_req_hi
    assign req_hi[g] = bus.wr_req[g] & (IDX_WIDTH'(g) > last_idx_q);
  end

  assign req_sel = (|req_hi) ? req_hi : bus.wr_req;
  assign win_oh  = req_sel & ~(req_sel - NUM_WR'(1));

  for (genvar b = 0; b < IDX_WIDTH; b++) begin : g_idx_bit
    for (genvar g = 0; g < NUM_WR; g++) begin : g_idx_wr
      assign idx_col[b][g] = win_oh[g] & (((g >> b) & 1) == 1);
    end
    assign win_idx[b] = |idx_col[b];
  end

  for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_data_bit
    for (genvar g = 0; g < NUM_WR; g++) begin : g_data_wr
      assign data_col[d][g] = win_oh[g] & bus.wr_data[g*DATA_WIDTH + d];
    end
    assign win_data[d] = |data_col[d];
  end

  always_comb begin
    state_d        = state_q;
    fifo_wr_en_d   = 1'b0;
    wr_ack_d       = '0;
    fifo_wr_data_d = fifo_wr_data_q;
    grant_idx_d    = grant_idx_q;
    last_idx_d     = last_idx_q;
    write_count_d  = write_count_q;
    case (state_q)
      ST_IDLE: begin
        if ((|bus.wr_req) && !bus.fifo_full) begin
          state_d        = ST_GRANT;
          fifo_wr_en_d   = 1'b1;
          wr_ack_d       = win_oh;
          fifo_wr_data_d = win_data;
          grant_idx_d    = win_idx;
          last_idx_d     = win_idx;
          write_count_d  = write_count_q + 32'd1;
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      fifo_wr_en_q   <= 1'b0;
      wr_ack_q       <= '0;
      fifo_wr_data_q <= '0;
      grant_idx_q    <= '0;
      last_idx_q     <= IDX_WIDTH'(NUM_WR - 1);
      write_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      wr_ack_q       <= wr_ack_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      grant_idx_q    <= grant_idx_d;
      last_idx_q     <= last_idx_d;
      write_count_q  <= write_count_d;
    end
  end

  assign bus.fifo_wr_en   = fifo_wr_en_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.fifo_wr_data = fifo_wr_data_q;
  assign bus.grant_idx    = grant_idx_q;
  assign bus.busy         = (state_q == ST_GRANT);
  assign bus.write_count  = write_count_q;

endmodule

`default_nettype wire

// File: doc/argo_chan_wr_arb.md
ARGO_CHAN_WR_ARB -- requirements
Module: argo_chan_wr_arb

Interface
REQ-001 Parameter NUM_WR, default 4: number of writer ports sharing one channel FIFO; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: channel element width in bits.
REQ-003 Parameter IDX_WIDTH, default 2: width of the grant index; SHALL satisfy (1 << IDX_WIDTH) >= NUM_WR.
REQ-004 Parameter ARB_ID, default 7: 16-bit identifier for this arbiter instance.
REQ-005 Port clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-006 Port rst  input  1: reset, synchronous, active-high.
REQ-007 Port wr_req  input  NUM_WR: per-writer send request; bit i means writer i holds a valid element.
REQ-008 Port wr_data  input  NUM_WR*DATA_WIDTH: packed writer data; writer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port wr_ack  output  NUM_WR: one-hot, one-cycle pulse meaning writer i's element has been accepted.
REQ-010 Port fifo_full  input  1: full flag from the channel FIFO.
REQ-011 Port fifo_wr_en  output  1: write strobe to the channel FIFO.
REQ-012 Port fifo_wr_data  output  DATA_WIDTH: data to the channel FIFO.
REQ-013 Port grant_idx  output  IDX_WIDTH: index of the most recently granted writer.
REQ-014 Port busy  output  1: high while the state is GRANT.
REQ-015 Port write_count  output  32: total number of elements forwarded since reset.

Function
REQ-016 The FSM SHALL have two states, IDLE and GRANT, and SHALL reset to IDLE.
REQ-017 IDLE -> GRANT when any wr_req bit is 1 and fifo_full is 0, both sampled at the edge; otherwise the FSM SHALL stay in IDLE.
REQ-018 GRANT -> IDLE unconditionally after one cycle; GRANT lasts exactly one cycle.
REQ-019 Winner selection SHALL be round-robin: the search starts at index (last_idx+1) mod NUM_WR and wraps. The first requesting index found wins.
REQ-020 On IDLE->GRANT the following SHALL be registered: fifo_wr_en=1, fifo_wr_data=winner's data, wr_ack bit[winner]=1, grant_idx=winner, last_idx=winner.
REQ-021 fifo_wr_en and wr_ack SHALL be high only during the GRANT cycle and 0 in every other cycle.
REQ-022 wr_req SHALL be ignored during GRANT; a writer drops wr_req, or presents new data, on the edge that ends its wr_ack cycle.
REQ-023 Maximum throughput SHALL be one element per 2 cycles; no element SHALL be written twice or dropped.
REQ-024 fifo_full=1 in IDLE SHALL block any grant; pending requests SHALL be held with no ack until fifo_full=0.
REQ-025 fifo_wr_data SHALL hold its last value outside GRANT.
REQ-026 write_count SHALL increment by 1 on every GRANT cycle and wrap modulo 2^32.
REQ-027 When the round-robin pointer is at the last index and requests remain, the search SHALL wrap: last_idx=NUM_WR-1 searches from index 0.
REQ-028 Requests from indices >= NUM_WR are impossible; grant_idx SHALL never exceed NUM_WR-1.

Reset
REQ-029 While rst=1 at an edge: state=IDLE, fifo_wr_en=0, wr_ack=0, fifo_wr_data=0, grant_idx=0, write_count=0, last_idx=NUM_WR-1, so writer 0 has first priority.
REQ-030 If rst is asserted during GRANT, the next cycle SHALL show all outputs at reset values, and the in-flight element counts as not sent.

Verification
REQ-031 After reset, wr_req=4'b0001, data0=0xA5, fifo_full=0 -> one cycle later fifo_wr_en=1, fifo_wr_data=0xA5, wr_ack=4'b0001, write_count=1.
REQ-032 All four writers request continuously, fifo_full=0 -> grants in order 0,1,2,3,0 on every second cycle; write_count=5 after 10 cycles.
REQ-033 wr_req=4'b1010, last_idx=1 -> writer 3 is granted, then writer 1.
REQ-034 fifo_full=1 with wr_req=4'b0100 for 5 cycles -> no fifo_wr_en and no wr_ack; fifo_full drops -> grant to writer 2 one cycle later.
REQ-035 rst asserted during GRANT -> next cycle fifo_wr_en=0, wr_ack=0, write_count=0, and the next grant goes to writer 0.
REQ-036 Writer 1 holds wr_req high across its ack with new data 0x11 then 0x22 (other writers idle) -> FIFO receives 0x11, then 0x22 exactly once each.
